// File: rtl/pl_inst_prefetch_queue.sv
// Instruction prefetch queue: keeps up to MAX_OUTSTANDING in-order bus reads in flight ahead of ID and buffers DEPTH fetched words.
// Latency: accept at cycle N, response at N+1, head visible at N+2 (registered head, no bypass).
// Backpressure: issue stops when queued + live reads would exceed DEPTH or MAX_OUTSTANDING is reached; a wait_req-held request stays stable.
module pl_inst_prefetch_queue #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0040_0000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  input  logic                   consume,
  output logic                   inst_available,
  output logic [31:0]            inst,
  output logic [31:0]            inst_pc,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   inst_read_enable,
  output logic [31:0]            inst_addr,
  input  logic                   inst_wait_req,
  input  logic                   inst_valid,
  input  logic [31:0]            inst_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  // Queue storage and in-order tag FIFO holding the address of every accepted read.
  logic [31:0]   q_data [DEPTH];
  logic [31:0]   q_pc   [DEPTH];
  logic [31:0]   tag_q  [MAX_OUTSTANDING];

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [CW-1:0] outst_q, outst_d, stale_q, stale_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   held_addr_q, held_addr_d;
  logic          held_q, held_d;
  logic          hold_stale_q, hold_stale_d;

  logic [CW-1:0] live;
  logic          room, accept, rsp, push, pop;
  logic          unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc[1:0];

  assign live   = outst_q - stale_q;
  assign room   = ((CW+1)'(count_q) + (CW+1)'(live)) < (CW+1)'(DEPTH);

  // A held request keeps priority over everything, including a redirect.
  assign inst_read_enable = reset &&
                            (held_q || (!redirect && room && (outst_q < CW'(MAX_OUTSTANDING))));
  assign inst_addr        = held_q ? held_addr_q : fetch_pc_q;

  assign accept = inst_read_enable && !inst_wait_req;
  assign rsp    = inst_valid && (outst_q != '0);
  assign push   = rsp && (stale_q == '0) && !redirect;
  assign pop    = consume && (count_q != '0) && !redirect;

  assign inst_available = (count_q != '0);
  assign occupancy      = count_q;
  assign inst           = inst_available ? q_data[head_q] : '0;
  assign inst_pc        = inst_available ? q_pc[head_q]   : '0;

  // Next-state: fetch pointer, counters, queue pointers; redirect overrides queue and fetch state last.
  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    tag_wr_d     = tag_wr_q;
    tag_rd_d     = tag_rd_q;
    fetch_pc_d   = fetch_pc_q;
    outst_d      = outst_q + CW'(accept) - CW'(rsp);
    stale_d      = stale_q - CW'(rsp && (stale_q != '0)) + CW'(accept && hold_stale_q);
    held_d       = inst_read_enable && inst_wait_req;
    held_addr_d  = held_d ? inst_addr : held_addr_q;
    hold_stale_d = held_d && (redirect || hold_stale_q);

    if (accept) begin
      tag_wr_d = (tag_wr_q == TW'(MAX_OUTSTANDING - 1)) ? '0 : tag_wr_q + TW'(1);
      // A request held across a redirect was already aimed at the old stream; the
      // fetch pointer now belongs to the redirect target and must not advance.
      if (!hold_stale_q) fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (rsp)  tag_rd_d = (tag_rd_q == TW'(MAX_OUTSTANDING - 1)) ? '0 : tag_rd_q + TW'(1);
    if (push) tail_d   = tail_q + PW'(1);
    if (pop)  head_d   = head_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);

    if (redirect) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      stale_d    = outst_d;
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      tag_wr_q     <= '0;
      tag_rd_q     <= '0;
      outst_q      <= '0;
      stale_q      <= '0;
      fetch_pc_q   <= RESET_PC;
      held_addr_q  <= RESET_PC;
      held_q       <= 1'b0;
      hold_stale_q <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      tag_wr_q     <= tag_wr_d;
      tag_rd_q     <= tag_rd_d;
      outst_q      <= outst_d;
      stale_q      <= stale_d;
      fetch_pc_q   <= fetch_pc_d;
      held_addr_q  <= held_addr_d;
      held_q       <= held_d;
      hold_stale_q <= hold_stale_d;
    end
  end

  // Payload storage; contents are qualified by the counters so it needs no reset.
  always_ff @(posedge clock) begin
    if (accept) tag_q[tag_wr_q] <= inst_addr;
    if (push) begin
      q_data[tail_q] <= inst_data;
      q_pc[tail_q]   <= tag_q[tag_rd_q];
    end
  end

endmodule

// File: tb/tb_pl_inst_prefetch_queue.sv
// Directed bench for pl_inst_prefetch_queue with a 1-cycle in-order memory responder.
// Inputs change at negedge, outputs are sampled shortly after; responder answers the cycle after accept.
// Memory can be stalled (mem_en=0) and a stray response injected (force_vld).
module tb_pl_inst_prefetch_queue;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] KEY    = 32'hA5A5_5A5A;

  logic        clock;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        consume;
  logic        inst_available;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [2:0]  occupancy;
  logic        inst_read_enable;
  logic [31:0] inst_addr;
  logic        inst_wait_req;
  logic        inst_valid;
  logic [31:0] inst_data;

  int          checks;
  int          errors;
  logic        mem_en;
  logic        force_vld;
  int          acc_count;
  logic        acc_seen;
  logic [31:0] acc_addr;
  logic [31:0] pend [$];

  pl_inst_prefetch_queue #(
    .DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(RST_PC)
  ) dut (
    .clock(clock), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .consume(consume), .inst_available(inst_available), .inst(inst), .inst_pc(inst_pc),
    .occupancy(occupancy), .inst_read_enable(inst_read_enable), .inst_addr(inst_addr),
    .inst_wait_req(inst_wait_req), .inst_valid(inst_valid), .inst_data(inst_data)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // In-order memory: records accepts just before the edge, answers one cycle later.
  initial begin
    inst_valid = 1'b0;
    inst_data  = '0;
    acc_count  = 0;
    acc_seen   = 1'b0;
    acc_addr   = '0;
    forever begin
      @(negedge clock); #2;
      acc_seen = inst_read_enable && !inst_wait_req;
      acc_addr = inst_addr;
      if (acc_seen) acc_count++;
      @(posedge clock); #2;
      if (acc_seen) pend.push_back(acc_addr);
      if (!reset) begin
        pend.delete();
        inst_valid = 1'b0;
        inst_data  = '0;
      end else if (mem_en && pend.size() != 0) begin
        inst_valid = 1'b1;
        inst_data  = pend.pop_front() ^ KEY;
      end else begin
        inst_valid = force_vld;
        inst_data  = 32'hDEAD_BEEF;
      end
    end
  end

  task automatic cyc();
    @(negedge clock);
    checks++;
    if (occupancy > 3'd4 || dut.outst_q > 3'd2 || dut.stale_q > 3'd2) begin
      errors++;
      $display("FAIL bounds occ=%0d outst=%0d stale=%0d limits 4/2/2",
               occupancy, dut.outst_q, dut.stale_q);
    end
  endtask

  task automatic do_reset(input logic c, input logic w, input logic m);
    cyc();
    reset = 1'b0; redirect = 1'b0; redirect_pc = '0;
    consume = c; inst_wait_req = w; mem_en = m; force_vld = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    cyc(); #1;
    checks++; if (inst_read_enable !== 1'b0) begin errors++; $display("FAIL rst_rd_en got %b exp 0", inst_read_enable); end
    checks++; if (inst_available !== 1'b0)   begin errors++; $display("FAIL rst_avail got %b exp 0", inst_available); end
    checks++; if (occupancy !== 3'd0)        begin errors++; $display("FAIL rst_occ got %0d exp 0", occupancy); end
    checks++; if (inst !== 32'h0)            begin errors++; $display("FAIL rst_inst got %h exp 0", inst); end
    checks++; if (inst_pc !== 32'h0)         begin errors++; $display("FAIL rst_inst_pc got %h exp 0", inst_pc); end
    checks++; if (inst_addr !== RST_PC)      begin errors++; $display("FAIL rst_addr got %h exp %h", inst_addr, RST_PC); end
  endtask

  task automatic test_stream();
    logic [31:0] ea, ep;
    do_reset(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      if (k != 0) cyc();
      #1;
      ea = RST_PC + 32'(4 * k);
      checks++; if (inst_read_enable !== 1'b1 || inst_addr !== ea) begin
        errors++; $display("FAIL stream_addr k=%0d got en=%b %h exp en=1 %h", k, inst_read_enable, inst_addr, ea); end
      if (k < 2) begin
        checks++; if (inst_available !== 1'b0) begin errors++; $display("FAIL stream_early_avail k=%0d got 1 exp 0", k); end
      end else begin
        ep = RST_PC + 32'(4 * (k - 2));
        checks++; if (inst_available !== 1'b1 || inst_pc !== ep || inst !== (ep ^ KEY)) begin
          errors++; $display("FAIL stream_head k=%0d got av=%b pc=%h d=%h exp av=1 pc=%h d=%h",
                             k, inst_available, inst_pc, inst, ep, ep ^ KEY); end
      end
    end
  endtask

  task automatic test_fill();
    int base;
    do_reset(1'b0, 1'b0, 1'b1);
    base = acc_count;
    repeat (8) cyc();
    #1;
    checks++; if (acc_count - base !== 4) begin errors++; $display("FAIL fill_accepts got %0d exp 4", acc_count - base); end
    checks++; if (occupancy !== 3'd4 || inst_read_enable !== 1'b0) begin
      errors++; $display("FAIL fill_full got occ=%0d en=%b exp occ=4 en=0", occupancy, inst_read_enable); end
    checks++; if (inst_pc !== RST_PC || inst !== (RST_PC ^ KEY)) begin
      errors++; $display("FAIL fill_head got %h/%h exp %h/%h", inst_pc, inst, RST_PC, RST_PC ^ KEY); end
    consume = 1'b1;
    cyc();
    consume = 1'b0;
    #1;
    checks++; if (inst_read_enable !== 1'b1 || inst_addr !== 32'h0040_0010 || inst_pc !== 32'h0040_0004 || occupancy !== 3'd3) begin
      errors++; $display("FAIL fill_pop got en=%b addr=%h pc=%h occ=%0d exp 1/00400010/00400004/3",
                         inst_read_enable, inst_addr, inst_pc, occupancy); end
    repeat (4) cyc();
    #1;
    checks++; if (acc_count - base !== 5 || occupancy !== 3'd4 || inst_read_enable !== 1'b0) begin
      errors++; $display("FAIL fill_refill got acc=%0d occ=%0d en=%b exp 5/4/0", acc_count - base, occupancy, inst_read_enable); end
  endtask

  task automatic test_wait();
    int base;
    do_reset(1'b1, 1'b1, 1'b1);
    base = acc_count;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) cyc();
      #1;
      checks++; if (inst_read_enable !== 1'b1 || inst_addr !== RST_PC) begin
        errors++; $display("FAIL wait_hold k=%0d got en=%b %h exp 1 %h", k, inst_read_enable, inst_addr, RST_PC); end
    end
    inst_wait_req = 1'b0;
    cyc();
    inst_wait_req = 1'b1;
    #1;
    checks++; if (acc_count - base !== 1 || inst_addr !== 32'h0040_0004) begin
      errors++; $display("FAIL wait_single_accept got acc=%0d addr=%h exp 1 00400004", acc_count - base, inst_addr); end
    inst_wait_req = 1'b0;
  endtask

  task automatic test_redirect_outstanding();
    do_reset(1'b0, 1'b0, 1'b0);
    cyc(); cyc(); #1;
    checks++; if (inst_read_enable !== 1'b0 || occupancy !== 3'd0) begin
      errors++; $display("FAIL ro_limit got en=%b occ=%0d exp 0/0", inst_read_enable, occupancy); end
    redirect = 1'b1; redirect_pc = 32'h0040_0103; mem_en = 1'b1;
    cyc();
    redirect = 1'b0;
    #1;
    checks++; if (occupancy !== 3'd0 || inst_available !== 1'b0 || inst_read_enable !== 1'b0) begin
      errors++; $display("FAIL ro_flush got occ=%0d av=%b en=%b exp 0/0/0", occupancy, inst_available, inst_read_enable); end
    cyc(); #1;
    checks++; if (inst_read_enable !== 1'b1 || inst_addr !== 32'h0040_0100 || inst_available !== 1'b0) begin
      errors++; $display("FAIL ro_target got en=%b addr=%h av=%b exp 1/00400100/0", inst_read_enable, inst_addr, inst_available); end
    cyc(); #1;
    checks++; if (inst_available !== 1'b0 || inst_addr !== 32'h0040_0104) begin
      errors++; $display("FAIL ro_discard got av=%b addr=%h exp 0/00400104", inst_available, inst_addr); end
    cyc(); #1;
    checks++; if (inst_available !== 1'b1 || inst_pc !== 32'h0040_0100 || inst !== (32'h0040_0100 ^ KEY)) begin
      errors++; $display("FAIL ro_first got av=%b pc=%h d=%h exp 1/00400100/%h", inst_available, inst_pc, inst, 32'h0040_0100 ^ KEY); end
  endtask

  task automatic test_redirect_held();
    do_reset(1'b1, 1'b1, 1'b1);
    cyc();
    redirect = 1'b1; redirect_pc = 32'h0040_0200;
    #1;
    checks++; if (inst_read_enable !== 1'b1 || inst_addr !== RST_PC) begin
      errors++; $display("FAIL rh_stable_redir got en=%b addr=%h exp 1/%h", inst_read_enable, inst_addr, RST_PC); end
    cyc();
    redirect = 1'b0;
    #1;
    checks++; if (inst_read_enable !== 1'b1 || inst_addr !== RST_PC) begin
      errors++; $display("FAIL rh_stable_after got en=%b addr=%h exp 1/%h", inst_read_enable, inst_addr, RST_PC); end
    inst_wait_req = 1'b0;
    cyc(); #1;
    checks++; if (inst_read_enable !== 1'b1 || inst_addr !== 32'h0040_0200) begin
      errors++; $display("FAIL rh_target got en=%b addr=%h exp 1/00400200", inst_read_enable, inst_addr); end
    cyc(); #1;
    checks++; if (inst_available !== 1'b0 || inst_addr !== 32'h0040_0204) begin
      errors++; $display("FAIL rh_discard got av=%b addr=%h exp 0/00400204", inst_available, inst_addr); end
    cyc(); #1;
    checks++; if (inst_available !== 1'b1 || inst_pc !== 32'h0040_0200 || inst !== (32'h0040_0200 ^ KEY)) begin
      errors++; $display("FAIL rh_first got av=%b pc=%h d=%h exp 1/00400200/%h", inst_available, inst_pc, inst, 32'h0040_0200 ^ KEY); end
  endtask

  task automatic test_collision_and_reset();
    do_reset(1'b0, 1'b0, 1'b1);
    repeat (7) cyc();
    #1;
    checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL col_full got %0d exp 4", occupancy); end
    force_vld = 1'b1;
    cyc();
    force_vld = 1'b0; redirect = 1'b1; redirect_pc = 32'h0040_0300; consume = 1'b1;
    #1;
    checks++; if (inst_read_enable !== 1'b0) begin errors++; $display("FAIL col_no_issue got %b exp 0", inst_read_enable); end
    cyc();
    redirect = 1'b0; consume = 1'b0;
    #1;
    checks++; if (occupancy !== 3'd0 || inst_available !== 1'b0 || inst_read_enable !== 1'b1 || inst_addr !== 32'h0040_0300) begin
      errors++; $display("FAIL col_after got occ=%0d av=%b en=%b addr=%h exp 0/0/1/00400300",
                         occupancy, inst_available, inst_read_enable, inst_addr); end
    cyc(); cyc(); #1;
    checks++; if (inst_available !== 1'b1 || inst_pc !== 32'h0040_0300 || occupancy !== 3'd1) begin
      errors++; $display("FAIL col_first got av=%b pc=%h occ=%0d exp 1/00400300/1", inst_available, inst_pc, occupancy); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (inst_read_enable !== 1'b0 || inst_available !== 1'b0 || occupancy !== 3'd0) begin
      errors++; $display("FAIL arst_ctl got en=%b av=%b occ=%0d exp 0/0/0", inst_read_enable, inst_available, occupancy); end
    checks++; if (inst !== 32'h0 || inst_pc !== 32'h0 || inst_addr !== RST_PC) begin
      errors++; $display("FAIL arst_data got inst=%h pc=%h addr=%h exp 0/0/%h", inst, inst_pc, inst_addr, RST_PC); end
    cyc(); cyc();
    reset = 1'b1;
    cyc();
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0; redirect = 1'b0; redirect_pc = '0; consume = 1'b0;
    inst_wait_req = 1'b0; mem_en = 1'b1; force_vld = 1'b0;
    test_reset();
    test_stream();
    test_fill();
    test_wait();
    test_redirect_outstanding();
    test_redirect_held();
    test_collision_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pl_inst_prefetch_queue.md
Name: pl_inst_prefetch_queue

Overview:
Parametrised successor to the pipelined core's text memory interface. It fetches instructions ahead of the ID stage into a DEPTH-entry in-order FIFO and keeps up to MAX_OUTSTANDING bus reads in flight. On a redirect (taken branch or jump) it flushes the queue and discards stale responses. It sits between the instruction bus and pipeline_datapath, replacing the single-entry text interface and its control block.

Parameters:
DEPTH, 4, queue entries; power of two, 2..16
MAX_OUTSTANDING, 2, maximum accepted-but-unanswered bus reads; 1..DEPTH
RESET_PC, 32'h00400000, first fetch address after reset

Ports:
clock  input  1  core clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset
redirect  input  1  flush and restart fetch at redirect_pc
redirect_pc  input  32  new fetch address; bits [1:0] ignored and treated as 0
consume  input  1  ID stage takes the head entry this cycle
inst_available  output  1  queue non-empty
inst  output  32  head instruction word
inst_pc  output  32  address of the head instruction
occupancy  output  $clog2(DEPTH)+1  number of valid entries
inst_read_enable  output  1  bus read request
inst_addr  output  32  bus read address, word-aligned
inst_wait_req  input  1  bus not accepting the request this cycle
inst_valid  input  1  read response valid; responses return in order, at most one per cycle
inst_data  input  32  response data

Behaviour:
- Reset (reset=0, asynchronous): queue empty, fetch_pc=RESET_PC, outstanding=0, stale=0, held=0.
  - Outputs during reset: inst_read_enable=0, inst_available=0, occupancy=0, inst=0, inst_pc=0, inst_addr=RESET_PC.
- Issue condition, when held=0: redirect=0 AND occupancy+live<DEPTH AND outstanding<MAX_OUTSTANDING.
  - live = outstanding-stale.
  - When the condition holds: inst_read_enable=1, inst_addr=fetch_pc.
- Acceptance: request is accepted when inst_read_enable=1 AND inst_wait_req=0.
  - On accept: fetch_pc+=4 (wraps modulo 2^32), outstanding+=1, issued address pushed into an in-order pc tag FIFO of depth MAX_OUTSTANDING.
- Hold: while inst_read_enable=1 and inst_wait_req=1, held=1. inst_read_enable and inst_addr stay stable until acceptance, including across a redirect.
- Response (inst_valid=1): outstanding-=1 and the pc tag is popped.
  - If stale>0: stale-=1 and the data is discarded.
  - Otherwise {inst_data, tag} is written to the tail. Space is guaranteed by the issue rule.
  - inst_valid with outstanding=0 is a protocol error and is ignored.
- Head: inst, inst_pc and inst_available are driven from registered queue state (no bypass).
  - Minimum latency: accept at cycle N, inst_valid at N+1, inst_available at N+2.
- Consume: pops the head. consume while empty is ignored. Push and pop in the same cycle leave occupancy unchanged, including when full.
- Redirect: takes priority over consume and over a same-cycle response write.
  - Queue is emptied; fetch_pc<=redirect_pc.
  - stale<=outstanding after this cycle's accept and response are counted (includes a held request accepted later: stale also increments on acceptance of a request issued before the redirect).
  - No new request is issued in the redirect cycle; first new request is the next cycle.
- New fetches may be issued while stale responses are pending. In-order return guarantees that stale data precedes live data.
- Counters never exceed MAX_OUTSTANDING; occupancy never exceeds DEPTH. Assertions in the bench check both.
- Reset asserted mid-transaction drops all in-flight state. The bus side is required to be reset together with the core.

Test Plan:
- Zero-wait memory, consume held at 1, DEPTH=4 → addresses 0x00400000, 0x00400004, ... issued back-to-back; inst_pc sequence matches; first inst_available two cycles after first accept.
- consume=0 with zero-wait memory → exactly 4 requests accepted, occupancy=4, inst_read_enable=0 thereafter; one consume → exactly one new request.
- inst_wait_req=1 for 3 cycles on the first request → inst_addr held at 0x00400000 for 4 cycles; only one accept counted.
- Two reads outstanding, then redirect to 0x00400100 → queue empty next cycle; both old responses discarded; first delivered inst_pc=0x00400100.
- Redirect while a request is held under wait_req → request stays stable until accepted, its response is discarded, next fetch goes to the redirect target.
- Redirect, consume and inst_valid in the same cycle with occupancy=DEPTH → occupancy=0, response dropped, no underflow or overflow; async reset mid-burst → all outputs reach reset values immediately.
